// File: rtl/axis_s2_m1_frame_sched_pkg.sv
// axis_sw_pkg: shared state encoding and default geometry for the stream switch blocks
package axis_sw_pkg;
  typedef enum logic [1:0] {SYNC = 2'd0, RUN = 2'd1, SWITCH = 2'd2} state_t;
  localparam int LINES_PER_FRAME_DEF = 1080;
  localparam int FRAME_CNT_W_DEF = 16;
endpackage

// File: rtl/axis_s2_m1_frame_sched_if.sv
// axis_s2_m1_frame_sched_if: selected-source handshake as seen after the switch
interface axis_s2_m1_frame_sched_if;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;
  modport master(output tvalid, tready, tuser, tlast);
  modport slave(input tvalid, tready, tuser, tlast);
endinterface

// File: rtl/axis_s2_m1_frame_sched_tracker.sv
// axis_frame_tracker: beat/SOF detection, line counting, frame-done and framing-error detection
module axis_frame_tracker #(
  parameter int LINES_PER_FRAME = 1080,
  parameter int LINE_CNT_W = 11
) (
  input  logic aclk,
  input  logic areset,
  input  logic en,
  input  logic tvalid,
  input  logic tready,
  input  logic tuser,
  input  logic tlast,
  output logic beat,
  output logic sof_seen,
  output logic frame_done,
  output logic frame_err
);
  logic [LINE_CNT_W-1:0] line_cnt;
  logic wrapped;
  assign beat = tvalid & tready;
  assign sof_seen = tvalid & tuser;
  assign frame_done = en & beat & tlast & (line_cnt == LINE_CNT_W'(LINES_PER_FRAME - 1));
  // after the last line only a new SOF may follow; a stray SOF mid-frame restarts the count
  assign frame_err = en & beat & ~frame_done &
                     ((tuser & ~tlast & (line_cnt != '0)) | (wrapped & ~tuser));
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      line_cnt <= '0;
      wrapped <= 1'b0;
    end else if (!en) begin
      line_cnt <= '0;
      wrapped <= 1'b0;
    end else if (beat) begin
      line_cnt <= (frame_done || frame_err) ? '0 : line_cnt + LINE_CNT_W'(tlast);
      wrapped <= frame_done;
    end
endmodule

// File: rtl/axis_s2_m1_frame_sched.sv
// axis_s2_m1_frame_sched: frame-boundary source scheduler for the 2:1 stream switch
module axis_s2_m1_frame_sched
  import axis_sw_pkg::*;
#(
  parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF,
  parameter int LINE_CNT_W = 11,
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEF,
  parameter int TO_W = 24
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   sel_req,
  input  logic                   auto_en,
  input  logic [7:0]             auto_frames,
  axis_s2_m1_frame_sched_if.slave mon,
  output logic                   axis_tdest_sel,
  output logic                   discard,
  output logic                   locked,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   frame_err,
  output logic                   sync_timeout
);
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  state_t state, state_nx;
  logic beat, sof_seen, sof_beat, frame_done, trk_err, pending;
  logic [7:0] auto_cnt, af;
  logic [TO_W-1:0] to_cnt;
  axis_frame_tracker #(.LINES_PER_FRAME(LINES_PER_FRAME), .LINE_CNT_W(LINE_CNT_W)) u_trk (
    .aclk(aclk), .areset(areset), .en(state == RUN),
    .tvalid(mon.tvalid), .tready(mon.tready), .tuser(mon.tuser), .tlast(mon.tlast),
    .beat(beat), .sof_seen(sof_seen), .frame_done(frame_done), .frame_err(trk_err)
  );
  assign sof_beat = sof_seen & beat;
  assign af = (auto_frames == 8'd0) ? 8'd1 : auto_frames;
  assign pending = auto_en ? ({1'b0, auto_cnt} + 9'd1 >= {1'b0, af}) : (sel_req != axis_tdest_sel);
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= SYNC;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == SYNC) ? (sof_beat ? RUN : SYNC) :
               (state == RUN)  ? ((frame_done && pending) ? SWITCH : RUN) : SYNC;
  end
  // the SOF beat itself reaches the sink in the cycle it is presented
  always_comb begin
    locked = state == RUN;
    discard = (state == SYNC) ? ~sof_seen : (state != RUN);
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      axis_tdest_sel <= 1'b0;
      frame_cnt <= '0;
      auto_cnt <= '0;
      to_cnt <= '0;
      frame_err <= 1'b0;
      sync_timeout <= 1'b0;
    end else begin
      axis_tdest_sel <= axis_tdest_sel ^ (state == SWITCH);
      frame_cnt <= frame_cnt + FRAME_CNT_W'(frame_done);
      auto_cnt <= (state == SWITCH) ? 8'd0 : auto_cnt + 8'(frame_done);
      frame_err <= trk_err;
      sync_timeout <= (state == SYNC) && !sof_beat && (to_cnt == TO_LAST);
      to_cnt <= (state != SYNC || sof_beat || to_cnt == TO_LAST) ? '0 : to_cnt + TO_W'(1);
    end
endmodule

// File: tb/tb_axis_s2_m1_frame_sched.sv
// tb_axis_s2_m1_frame_sched: scoreboard bench for the frame scheduler with 4-line frames
module tb_axis_s2_m1_frame_sched;
  logic aclk = 1'b0, areset = 1'b1, sel_req = 1'b0, auto_en = 1'b0;
  logic [7:0] auto_frames = 8'd0;
  logic axis_tdest_sel, discard, locked, frame_err, sync_timeout;
  logic [15:0] frame_cnt;
  axis_s2_m1_frame_sched_if mon();
  axis_s2_m1_frame_sched #(.LINES_PER_FRAME(4), .TO_W(6)) dut (
    .aclk(aclk), .areset(areset), .sel_req(sel_req), .auto_en(auto_en), .auto_frames(auto_frames),
    .mon(mon), .axis_tdest_sel(axis_tdest_sel), .discard(discard), .locked(locked),
    .frame_cnt(frame_cnt), .frame_err(frame_err), .sync_timeout(sync_timeout)
  );
  always #5 aclk = ~aclk;
  typedef struct {int fc; logic sw;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0, err_pulses = 0, sel_toggles = 0;
  logic [15:0] prev_fc = 16'd0;
  logic prev_sel = 1'b0;
  logic m_sel = 1'b0;
  logic [7:0] m_auto = 8'd0;
  int m_fc = 0;
  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic u, input logic l);
    mon.tvalid = v;
    mon.tuser = u;
    mon.tlast = l;
    @(posedge aclk);
    #1;
  endtask
  task automatic lines(input int n, input logic sof);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 3; j++) drive(1'b1, sof && i == 0 && j == 0, j == 2);
  endtask
  task automatic frame_end();
    logic pend;
    m_fc++;
    m_auto++;
    pend = auto_en ? (m_auto >= ((auto_frames == 8'd0) ? 8'd1 : auto_frames)) : (sel_req != m_sel);
    sb.push_back('{m_fc, pend});
    chk("sel_t1", axis_tdest_sel, m_sel);
    chk("discard_t1", discard, pend);
    if (pend) begin
      m_sel = ~m_sel;
      m_auto = 8'd0;
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("sel_t2", axis_tdest_sel, m_sel);
    chk("discard_t2", discard, pend);
    drive(1'b0, 1'b0, 1'b0);
  endtask
  task automatic frame(input logic set_req, input logic req);
    lines(2, 1'b1);
    chk("discard_mid", discard, 0);
    if (set_req) begin
      sel_req = req;
      chk("sel_mid", axis_tdest_sel, m_sel);
    end
    lines(2, 1'b0);
    frame_end();
  endtask
  always @(negedge aclk) begin
    if (!areset && frame_cnt != prev_fc) begin
      if (sb.size() == 0) chk("sb_unexpected", frame_cnt, prev_fc);
      else begin
        e = sb.pop_front();
        chk("frame_cnt", frame_cnt, e.fc);
        chk("locked_t1", locked, !e.sw);
      end
    end
    if (!areset && axis_tdest_sel != prev_sel) sel_toggles++;
    prev_fc = frame_cnt;
    prev_sel = axis_tdest_sel;
    if (frame_err) err_pulses++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: no finish by 100000 ns");
    $fatal(1);
  end
  initial begin
    int fc0, t0, e0;
    int hits[$];
    mon.tvalid = 1'b0;
    mon.tready = 1'b1;
    mon.tuser = 1'b0;
    mon.tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    chk("rst_sel", axis_tdest_sel, 0);
    chk("rst_fc", frame_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_discard", discard, 1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("sync_discard", discard, 1);
    chk("sync_locked", locked, 0);
    mon.tuser = 1'b1;
    #1 chk("sof_discard", discard, 0);
    frame(1'b0, 1'b0);
    chk("fc_first", frame_cnt, 1);
    chk("locked_first", locked, 1);
    frame(1'b1, 1'b1);
    chk("sel_after_req", axis_tdest_sel, 1);
    mon.tvalid = 1'b1;
    mon.tuser = 1'b1;
    #1 chk("s1_sof_discard", discard, 0);
    frame(1'b0, 1'b0);
    auto_en = 1'b1;
    auto_frames = 8'd2;
    fc0 = frame_cnt;
    t0 = sel_toggles;
    repeat (8) frame(1'b0, 1'b0);
    chk("auto2_toggles", sel_toggles - t0, 4);
    chk("auto2_frames", frame_cnt - fc0, 8);
    chk("auto2_sel", axis_tdest_sel, 1);
    auto_frames = 8'd0;
    t0 = sel_toggles;
    repeat (2) frame(1'b0, 1'b0);
    chk("auto0_toggles", sel_toggles - t0, 2);
    auto_en = 1'b0;
    sel_req = m_sel;
    e0 = err_pulses;
    fc0 = frame_cnt;
    t0 = sel_toggles;
    lines(2, 1'b1);
    frame(1'b0, 1'b0);
    chk("err_pulse", err_pulses - e0, 1);
    chk("err_frames", frame_cnt - fc0, 1);
    chk("err_noswitch", sel_toggles - t0, 0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("pre_rst_sel", axis_tdest_sel, 1);
    #2 areset = 1'b1;
    #1;
    chk("arst_sel", axis_tdest_sel, 0);
    chk("arst_fc", frame_cnt, 0);
    chk("arst_discard", discard, 1);
    chk("arst_locked", locked, 0);
    m_sel = 1'b0;
    m_auto = 8'd0;
    m_fc = 0;
    mon.tvalid = 1'b0;
    mon.tuser = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge aclk);
      if (sync_timeout) hits.push_back(c);
    end
    chk("to_count", hits.size(), 3);
    chk("to_first", hits.size() > 0 ? hits[0] : 0, 64);
    chk("to_period", hits.size() > 1 ? hits[1] - hits[0] : 0, 63);
    chk("to_locked", locked, 0);
    chk("sb_drained", sb.size(), 0);
    chk("err_total", err_pulses, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
